mm_refill_ctrl: RTL

//   Main-memory refill engine upstream of the direct-mapped multiword cache.
//   On a cache miss it fetches the 2-word (64-bit) block holding the missed PC.
//   It reads both words from a 32-bit word-wide main memory using a req/ack handshake.
//   It then presents the block to the cache as Access_MM/Data_MM for exactly one cycle.

---
 rtl/mm_pkg.sv | 31 +++
 rtl/mm_refill_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
//   Shared definitions for the main-memory refill engine: FSM state encoding,
//   block geometry and a helper that aligns a PC to its block base.
// -----------------------------------------------------------------------------
package mm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD0  = 3'd1;
    localparam state_t ST_RD1  = 3'd2;
    localparam state_t ST_FILL = 3'd3;
    localparam state_t ST_GAP  = 3'd4;

    localparam int BLOCK_WORDS = 2;
    localparam int WORD_BYTES  = 4;
    localparam int BLOCK_BYTES = BLOCK_WORDS * WORD_BYTES;

    // Clears the byte-in-block bits so both words of the block are fetched
    // regardless of which word actually missed.
    function automatic logic [31:0] block_base(input logic [31:0] pc);
        return pc & ~(32'(BLOCK_BYTES) - 32'd1);
    endfunction

    // Byte address of word 'sel' inside the block starting at 'base'.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic sel);
        return base | (32'(sel) * 32'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/mm_refill_ctrl.sv
// -----------------------------------------------------------------------------
// mm_refill_ctrl
//   Refill engine in front of the direct-mapped two-word-block cache. On a
//   miss it reads the two 32-bit words of the block from main memory and then
//   hands the 64-bit block to the cache with a single-cycle Access_MM pulse.
//
// Ports
//   CLK, RESET        clock; synchronous active-high reset
//   Miss, Miss_PC     refill request level and missed PC (sampled in IDLE only)
//   Mem_Req, Mem_Addr memory read request and word byte address
//   Mem_Ack, Mem_RData memory response strobe and data
//   Access_MM, Data_MM one-cycle block-valid pulse and the refilled block
//   Busy              high whenever the engine is not idle
//   CNT_REFILL        completed refills (wrapping)
//   CNT_RETRY         timeout re-issues (saturating at 255)
//   state_dbg         current FSM state, for observation only
//
// Memory handshake: Mem_Req acts as 'valid' and Mem_Ack as 'ready+data'. The
// request and its address stay stable from the cycle Mem_Req rises until the
// rising edge on which Mem_Ack is seen high; that edge transfers Mem_RData. A
// Mem_Ack seen while Mem_Req is low (IDLE, FILL or the retry gap) transfers
// nothing and is ignored.
// -----------------------------------------------------------------------------
module mm_refill_ctrl
    import mm_pkg::*;
#(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Miss,
    input  logic [31:0]       Miss_PC,
    output logic              Mem_Req,
    output logic [31:0]       Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [31:0]       Mem_RData,
    output logic              Access_MM,
    output logic [63:0]       Data_MM,
    output logic              Busy,
    output logic [CNT_W-1:0]  CNT_REFILL,
    output logic [7:0]        CNT_RETRY,
    output logic [2:0]        state_dbg
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_next;
    logic [31:0]       base;
    logic              word_sel;    // 0: fetching low word, 1: fetching high word
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT));

    // ---------------------------------------------------------------- state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (Miss) state_next = ST_RD0;
            ST_RD0: begin
                // An ack on the timeout cycle still wins: the word has arrived.
                if (Mem_Ack)          state_next = ST_RD1;
                else if (timeout_hit) state_next = ST_GAP;
            end
            ST_RD1: begin
                if (Mem_Ack)          state_next = ST_FILL;
                else if (timeout_hit) state_next = ST_GAP;
            end
            ST_GAP:  state_next = word_sel ? ST_RD1 : ST_RD0;
            ST_FILL: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        Mem_Req   = (state == ST_RD0) || (state == ST_RD1);
        Access_MM = (state == ST_FILL);
        Busy      = (state != ST_IDLE);
        Mem_Addr  = word_addr(base, word_sel);
        state_dbg = state;
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge CLK) begin
        if (RESET) begin
            base       <= '0;
            word_sel   <= 1'b0;
            wait_cnt   <= '0;
            Data_MM    <= '0;
            CNT_REFILL <= '0;
            CNT_RETRY  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Miss) begin
                        base     <= block_base(Miss_PC);
                        word_sel <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                ST_RD0, ST_RD1: begin
                    if (Mem_Ack) begin
                        if (state == ST_RD0) begin
                            Data_MM[31:0] <= Mem_RData;
                            word_sel      <= 1'b1;
                        end else begin
                            Data_MM[63:32] <= Mem_RData;
                        end
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        wait_cnt <= '0;
                        if (CNT_RETRY != 8'hFF) CNT_RETRY <= CNT_RETRY + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_FILL: CNT_REFILL <= CNT_REFILL + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
